// File: rtl/sa_input_skewer_pkg.sv
// Shared constants, state encoding and helpers for the systolic-array input skewer.
package sa_input_skewer_pkg;

  localparam int SA_ROWS        = 8;
  localparam int SA_DATA_W      = 8;
  localparam int DATA_MAX_BITS  = SA_ROWS * SA_DATA_W;
  localparam int SKW_FIFO_DEPTH = 16;

  localparam logic [2:0] OP_CFG_CHANNEL = 3'b000;

  typedef enum logic [1:0] {
    SKW_IDLE   = 2'd0,
    SKW_STREAM = 2'd1,
    SKW_FLUSH  = 2'd2,
    SKW_DONE   = 2'd3
  } skw_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/sa_input_skewer_sync_fifo.sv
// Show-ahead synchronous FIFO with active-low synchronous reset; a push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module sa_input_skewer_sync_fifo
  import sa_input_skewer_pkg::*;
#(
  parameter int WIDTH = DATA_MAX_BITS,
  parameter int DEPTH = SKW_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sa_input_skewer.sv
// Buffers column vectors and launches them as a diagonal wavefront (lane r delayed r beats),
// then flushes with zeros and pulses done. Optional macro SKEW_STALL_CNT_EN adds stall_cnt.
module sa_input_skewer
  import sa_input_skewer_pkg::*;
#(
  parameter int ROWS       = SA_ROWS,
  parameter int DATA_W     = SA_DATA_W,
  parameter int WORD_SIZE  = 128,
  parameter int FIFO_DEPTH = SKW_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   config_valid,
  input  logic [2:0]             op,
  input  logic [7:0]             channel,
  input  logic                   DI_valid,
  input  logic [WORD_SIZE-1:0]   DI,
  input  logic                   sa_ready,
  output logic                   DO_valid,
  output logic [ROWS*DATA_W-1:0] DO,
  output logic [ROWS-1:0]        lane_valid,
  output logic                   done,
  output logic                   overflow
`ifdef SKEW_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int VW = ROWS * DATA_W;

  skw_state_e        r_state;
  skw_state_e        w_state_nxt;
  logic [7:0]        r_channel;
  logic [7:0]        r_vcnt;
  logic [7:0]        r_fcnt;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [VW-1:0]     w_fifo_rdata;
  logic              w_pop;
  logic              w_advance;
  logic              w_feed;
  logic              w_cfg;
  logic              w_drop;
  logic [DATA_W:0]   w_lane_in  [ROWS];
  logic [DATA_W:0]   w_lane_tap [ROWS];
  logic              r_do_valid;
  logic [VW-1:0]     r_do;
  logic [ROWS-1:0]   r_lane_valid;
  logic              r_done;
  logic              r_overflow;
  logic [WORD_SIZE-VW-1:0] w_unused_lo;

  assign w_unused_lo = DI[WORD_SIZE-VW-1:0];

  sa_input_skewer_sync_fifo #(
    .WIDTH (VW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (rst),
    .i_push  (DI_valid),
    .i_wdata (DI[WORD_SIZE-1 -: VW]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= SKW_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SKW_IDLE:   if (!w_fifo_empty) w_state_nxt = SKW_STREAM; else w_state_nxt = SKW_IDLE;
      SKW_STREAM: if (w_pop && (r_vcnt == r_channel - 8'd1)) w_state_nxt = SKW_FLUSH;
                  else w_state_nxt = SKW_STREAM;
      SKW_FLUSH:  if (w_advance && (r_fcnt == 8'(ROWS-2))) w_state_nxt = SKW_DONE;
                  else w_state_nxt = SKW_FLUSH;
      SKW_DONE:   w_state_nxt = SKW_IDLE;
      default:    w_state_nxt = SKW_IDLE;
    endcase
  end

  // FSM outputs: pop/advance strobes and whether real data feeds the lanes.
  always_comb begin
    w_pop     = 1'b0;
    w_advance = 1'b0;
    w_feed    = 1'b0;
    case (r_state)
      SKW_STREAM: begin
        w_pop     = sa_ready && !w_fifo_empty;
        w_advance = w_pop;
        w_feed    = 1'b1;
      end
      SKW_FLUSH: w_advance = sa_ready;
      default:   w_advance = 1'b0;
    endcase
  end

  // Lane inputs: {valid, data}; flush beats inject zero padding.
  always_comb begin
    for (int l = 0; l < ROWS; l++) begin
      w_lane_in[l] = w_feed ? {1'b1, w_fifo_rdata[VW-1-l*DATA_W -: DATA_W]} : '0;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    if (r == 0) begin : g_direct
      assign w_lane_tap[r] = w_lane_in[r];
    end else begin : g_delay
      logic [DATA_W:0] r_line [r];
      // Lane delay line: r stages, frozen whenever the wavefront does not advance.
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int k = 0; k < r; k++) r_line[k] <= '0;
        end else if (w_advance) begin
          r_line[0] <= w_lane_in[r];
          for (int k = 1; k < r; k++) r_line[k] <= r_line[k-1];
        end
      end
      assign w_lane_tap[r] = r_line[r-1];
    end
  end

  // Registered wavefront output; DO and lane_valid hold between advances.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_do_valid   <= 1'b0;
      r_do         <= '0;
      r_lane_valid <= '0;
    end else begin
      r_do_valid <= w_advance;
      if (w_advance) begin
        for (int l = 0; l < ROWS; l++) begin
          r_do[VW-1-l*DATA_W -: DATA_W] <= w_lane_tap[l][DATA_W-1:0];
          r_lane_valid[ROWS-1-l]        <= w_lane_tap[l][DATA_W];
        end
      end
    end
  end

  // Tile vector counter and flush beat counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vcnt <= 8'd0;
      r_fcnt <= 8'd0;
    end else begin
      if (r_state == SKW_IDLE) r_vcnt <= 8'd0;
      else if (w_pop)          r_vcnt <= r_vcnt + 8'd1;
      if (r_state == SKW_STREAM) r_fcnt <= 8'd0;
      else if (w_advance)        r_fcnt <= r_fcnt + 8'd1;
    end
  end

  assign w_cfg  = config_valid && (op == OP_CFG_CHANNEL) && (r_state == SKW_IDLE) && (channel != 8'd0);
  assign w_drop = DI_valid && w_fifo_full && !w_pop;

  // Channel config, sticky overflow (a drop outranks a clearing config) and done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_channel  <= 8'd1;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_cfg) r_channel <= channel;
      if (w_drop)     r_overflow <= 1'b1;
      else if (w_cfg) r_overflow <= 1'b0;
      r_done <= (r_state == SKW_DONE);
    end
  end

  assign DO_valid   = r_do_valid;
  assign DO         = r_do;
  assign lane_valid = r_lane_valid;
  assign done       = r_done;
  assign overflow   = r_overflow;

`ifdef SKEW_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ((r_state == SKW_STREAM) && (!sa_ready || w_fifo_empty)) ||
                   ((r_state == SKW_FLUSH) && !sa_ready);

  // Saturating count of cycles the wavefront was held back.
  always_ff @(posedge clk) begin
    if (!rst)         r_stall_cnt <= 16'd0;
    else if (w_cfg)   r_stall_cnt <= 16'd0;
    else if (w_stall) r_stall_cnt <= sat_inc16(r_stall_cnt);
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_sa_input_skewer.sv
// Self-checking bench for sa_input_skewer: directed tile sequences plus randomized tiles
// checked against a diagonal-wavefront reference model.
module tb_sa_input_skewer;

  localparam int ROWS = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         config_valid;
  logic [2:0]   op;
  logic [7:0]   channel;
  logic         DI_valid;
  logic [127:0] DI;
  logic         sa_ready;
  logic         DO_valid;
  logic [63:0]  DO;
  logic [7:0]   lane_valid;
  logic         done;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int hold_bad = 0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  lv;
    int          cyc;
  } beat_t;

  typedef struct {
    int          beat;
    logic [63:0] d;
    logic [7:0]  lv;
  } vec_t;

  beat_t       beats_q[$];
  int          done_q[$];
  logic [63:0] tile_vecs[$];
  logic [63:0] last_do;
  logic        prev_rst_low = 1'b1;

  sa_input_skewer dut (
    .clk          (clk),
    .rst          (rst),
    .config_valid (config_valid),
    .op           (op),
    .channel      (channel),
    .DI_valid     (DI_valid),
    .DI           (DI),
    .sa_ready     (sa_ready),
    .DO_valid     (DO_valid),
    .DO           (DO),
    .lane_valid   (lane_valid),
    .done         (done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log beats and done pulses; DO must hold while DO_valid is low.
  always @(negedge clk) begin
    if (DO_valid) beats_q.push_back('{DO, lane_valid, cyc});
    if (done) done_q.push_back(cyc);
    if (!prev_rst_low && !DO_valid && (DO !== last_do)) hold_bad <= hold_bad + 1;
    last_do      <= DO;
    prev_rst_low <= !rst;
  end

  // sa_ready pattern generator.
  initial begin
    sa_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       sa_ready = 1'b1;
        1:       sa_ready = ((cyc % 2) == 0);
        2:       sa_ready = ($urandom_range(0, 9) < 7);
        default: sa_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_cfg(input logic [7:0] ch);
    config_valid = 1'b1;
    op           = 3'b000;
    channel      = ch;
    tick();
    config_valid = 1'b0;
    channel      = 8'd0;
  endtask

  task automatic push_vec(input logic [63:0] v);
    DI_valid = 1'b1;
    DI       = {v, $urandom, $urandom};
    tile_vecs.push_back(v);
    tick();
    DI_valid = 1'b0;
  endtask

  function automatic logic [63:0] make_vec(input int k);
    logic [63:0] v;
    for (int r = 0; r < 8; r++) v[63-8*r -: 8] = 8'(r + 1 + 16*k);
    return v;
  endfunction

  function automatic logic [63:0] rand_vec();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_done(input int n, input string name);
    int budget = 400;
    while ((done_q.size() < n) && (budget > 0)) begin
      tick();
      budget--;
    end
    checks++;
    if (done_q.size() < n) begin
      errors++;
      $display("FAIL %s: timeout, done count %0d expected %0d", name, done_q.size(), n);
    end
  endtask

  // Reference: beat j, lane r carries vector j-r when 0 <= j-r < nvec, else zero padding.
  task automatic check_tile(input int vbase, input int nvec, input int bbase, input int didx,
                            input string name);
    int          nb;
    logic [63:0] ed;
    logic [7:0]  el;
    nb = nvec + ROWS - 1;
    checks++;
    if (beats_q.size() < bbase + nb) begin
      errors++;
      $display("FAIL %s beats: got %0d expected at least %0d", name, beats_q.size() - bbase, nb);
      return;
    end
    for (int j = 0; j < nb; j++) begin
      ed = '0;
      el = '0;
      for (int r = 0; r < ROWS; r++) begin
        if ((j - r >= 0) && (j - r < nvec)) begin
          ed[63-8*r -: 8] = tile_vecs[vbase + j - r][63-8*r -: 8];
          el[7-r]         = 1'b1;
        end
      end
      chk($sformatf("%s beat%0d DO", name, j), beats_q[bbase + j].d, ed);
      chk($sformatf("%s beat%0d lane_valid", name, j), 64'(beats_q[bbase + j].lv), 64'(el));
    end
    checks++;
    if (done_q.size() <= didx) begin
      errors++;
      $display("FAIL %s done: got none expected a pulse", name);
    end else begin
      checks--;
      chk($sformatf("%s done cycle", name), 64'(done_q[didx]), 64'(beats_q[bbase + nb - 1].cyc + 1));
    end
  endtask

  initial begin
    vec_t tbl[6];
    int   bb, db, vb, nb, ch;

    tbl[0] = '{0,  64'h0100000000000000, 8'b10000000};
    tbl[1] = '{1,  64'h1102000000000000, 8'b11000000};
    tbl[2] = '{3,  64'h3122130400000000, 8'b11110000};
    tbl[3] = '{4,  64'h0032231405000000, 8'b01111000};
    tbl[4] = '{7,  64'h0000000035261708, 8'b00001111};
    tbl[5] = '{10, 64'h0000000000000038, 8'b00000001};

    rst = 1'b0; config_valid = 1'b0; op = 3'b000; channel = 8'd0; DI_valid = 1'b0; DI = '0;
    tick(); tick(); tick();
    chk("reset DO_valid", 64'(DO_valid), 64'd0);
    chk("reset DO", DO, 64'd0);
    chk("reset lane_valid", 64'(lane_valid), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    rst = 1'b1;
    ready_mode = 0;
    tick(); tick();

    // Basic tile of 4, always ready, with hand-computed beats.
    do_cfg(8'd4);
    bb = beats_q.size(); db = done_q.size(); vb = tile_vecs.size();
    for (int k = 0; k < 4; k++) push_vec(make_vec(k));
    wait_done(db + 1, "t1");
    tick(); tick(); tick();
    chk("t1 beat count", 64'(beats_q.size() - bb), 64'd11);
    chk("t1 done count", 64'(done_q.size() - db), 64'd1);
    for (int i = 0; i < 6; i++) begin
      if (beats_q.size() > bb + tbl[i].beat) begin
        chk($sformatf("t1 table%0d DO", i), beats_q[bb + tbl[i].beat].d, tbl[i].d);
        chk($sformatf("t1 table%0d lane_valid", i), 64'(beats_q[bb + tbl[i].beat].lv), 64'(tbl[i].lv));
      end else begin
        chk($sformatf("t1 table%0d present", i), 64'(beats_q.size() - bb), 64'(tbl[i].beat + 1));
      end
    end
    check_tile(vb, 4, bb, db, "t1");

    // Same tile with sa_ready toggling.
    ready_mode = 1;
    tick();
    bb = beats_q.size(); db = done_q.size(); vb = tile_vecs.size();
    for (int k = 0; k < 4; k++) push_vec(make_vec(k));
    wait_done(db + 1, "t2");
    tick(); tick(); tick();
    chk("t2 beat count", 64'(beats_q.size() - bb), 64'd11);
    check_tile(vb, 4, bb, db, "t2");
    if (beats_q.size() >= bb + 11)
      chk("t2 gaps present", 64'(beats_q[bb + 10].cyc - beats_q[bb].cyc > 10), 64'd1);

    // Overflow: 17 pushes with the array stalled.
    ready_mode = 3;
    tick(); tick(); tick();
    bb = beats_q.size(); db = done_q.size(); vb = tile_vecs.size();
    for (int i = 0; i < 17; i++) begin
      DI_valid = 1'b1;
      DI       = {rand_vec(), rand_vec()};
      if (i < 16) tile_vecs.push_back(DI[127:64]);
      tick();
      if (i == 15) chk("t3 overflow after 16", 64'(overflow), 64'd0);
      if (i == 16) chk("t3 overflow after 17", 64'(overflow), 64'd1);
    end
    DI_valid = 1'b0;
    tick(); tick(); tick();
    chk("t3 no output while stalled", 64'(beats_q.size() - bb), 64'd0);
    ready_mode = 0;
    wait_done(db + 4, "t3");
    for (int i = 0; i < 10; i++) tick();
    chk("t3 beat count", 64'(beats_q.size() - bb), 64'd44);
    for (int t = 0; t < 4; t++) check_tile(vb + 4*t, 4, bb + 11*t, db + t, $sformatf("t3 tile%0d", t));
    chk("t3 overflow sticky", 64'(overflow), 64'd1);
    do_cfg(8'd4);
    chk("t3 overflow cleared", 64'(overflow), 64'd0);

    // Tile of 2, next tile arrives during flush.
    do_cfg(8'd2);
    bb = beats_q.size(); db = done_q.size(); vb = tile_vecs.size();
    push_vec(rand_vec()); push_vec(rand_vec());
    tick(); tick();
    push_vec(rand_vec()); push_vec(rand_vec());
    wait_done(db + 2, "t4");
    tick(); tick(); tick();
    chk("t4 beat count", 64'(beats_q.size() - bb), 64'd18);
    check_tile(vb, 2, bb, db, "t4a");
    check_tile(vb + 2, 2, bb + 9, db + 1, "t4b");
    if ((beats_q.size() > bb + 9) && (done_q.size() > db))
      chk("t4 restart latency", 64'(beats_q[bb + 9].cyc), 64'(done_q[db] + 2));

    // Config during STREAM ignored; channel=0 in IDLE ignored.
    do_cfg(8'd4);
    bb = beats_q.size(); db = done_q.size(); vb = tile_vecs.size();
    push_vec(rand_vec());
    tick(); tick();
    do_cfg(8'd9);
    for (int k = 0; k < 3; k++) push_vec(rand_vec());
    wait_done(db + 1, "t5a");
    tick(); tick(); tick();
    chk("t5a beat count", 64'(beats_q.size() - bb), 64'd11);
    check_tile(vb, 4, bb, db, "t5a");
    do_cfg(8'd0);
    bb = beats_q.size(); db = done_q.size(); vb = tile_vecs.size();
    for (int k = 0; k < 4; k++) push_vec(rand_vec());
    wait_done(db + 1, "t5b");
    tick(); tick(); tick();
    chk("t5b beat count", 64'(beats_q.size() - bb), 64'd11);
    check_tile(vb, 4, bb, db, "t5b");

    // Reset in the middle of the flush, with two vectors still queued.
    do_cfg(8'd4);
    bb = beats_q.size(); db = done_q.size();
    for (int k = 0; k < 6; k++) push_vec(rand_vec());
    for (int b = 0; (b < 100) && (beats_q.size() < bb + 6); b++) tick();
    chk("t6 reached flush", 64'(beats_q.size() >= bb + 6), 64'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6 DO_valid", 64'(DO_valid), 64'd0);
    chk("t6 DO", DO, 64'd0);
    chk("t6 lane_valid", 64'(lane_valid), 64'd0);
    chk("t6 done", 64'(done), 64'd0);
    chk("t6 overflow", 64'(overflow), 64'd0);
    nb = beats_q.size();
    for (int i = 0; i < 30; i++) tick();
    chk("t6 no beats after reset", 64'(beats_q.size() - nb), 64'd0);
    chk("t6 no done", 64'(done_q.size() - db), 64'd0);
    // After reset the tile length is one vector.
    bb = beats_q.size(); db = done_q.size(); vb = tile_vecs.size();
    push_vec(rand_vec());
    wait_done(db + 1, "t6 post");
    tick(); tick(); tick();
    chk("t6 post beat count", 64'(beats_q.size() - bb), 64'd8);
    check_tile(vb, 1, bb, db, "t6 post");

    // Randomized tiles with random ready and push gaps.
    ready_mode = 2;
    for (int t = 0; t < 6; t++) begin
      ch = $urandom_range(1, 6);
      do_cfg(8'(ch));
      bb = beats_q.size(); db = done_q.size(); vb = tile_vecs.size();
      for (int k = 0; k < ch; k++) begin
        push_vec(rand_vec());
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end
      wait_done(db + 1, $sformatf("rand%0d", t));
      tick(); tick(); tick();
      chk($sformatf("rand%0d beat count", t), 64'(beats_q.size() - bb), 64'(ch + ROWS - 1));
      check_tile(vb, ch, bb, db, $sformatf("rand%0d", t));
    end

    chk("DO hold violations", 64'(hold_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_input_skewer.md
Name: sa_input_skewer

Overview:
- Downstream neighbour of the data rotator.
- Accepts transposed 8-byte column vectors (DI_valid/DI[127:64]) and buffers them in a small FIFO.
- Feeds the 8-row systolic array edge as a diagonal wavefront: lane r is delayed r beats relative to lane 0.
- After the last vector of a tile, flushes the skew pipeline with zeros, then pulses done.

Parameters:
ROWS, 8, number of systolic array rows/lanes
DATA_W, 8, bits per lane element
WORD_SIZE, 128, input word width (only upper ROWS*DATA_W bits carry data)
FIFO_DEPTH, 16, input vector FIFO entries (power of two)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-low reset
config_valid  input  1  configuration strobe
op  input  3  config opcode; 3'b000 = load channel
channel  input  8  vectors per tile
DI_valid  input  1  one column vector present on DI
DI  input  WORD_SIZE  DI[127:64] = lanes 0..7 (lane r = DI[127-8r -: 8]); DI[63:0] ignored
sa_ready  input  1  array accepts a wavefront this cycle
DO_valid  output  1  DO holds a wavefront
DO  output  ROWS*DATA_W  DO[63:56] = lane 0 ... DO[7:0] = lane 7
lane_valid  output  ROWS  per-lane real-data flag (0 = skew/flush padding)
done  output  1  one-cycle pulse after tile flush completes
overflow  output  1  sticky: push attempted while FIFO full

Behaviour:
- Reset: all state clears synchronously when rst=0.
  - Outputs: DO_valid=0, DO=0, lane_valid=0, done=0, overflow=0.
  - Internal: FIFO empty, skew delay lines zero, channel_reg=1, state=IDLE.
  - A reset mid-tile discards all buffered data.
- Config: applies only in IDLE, with config_valid=1 and op=3'b000.
  - channel_reg<=channel, overflow<=0.
  - channel=0 is ignored; channel_reg is unchanged.
  - Outside IDLE, config is ignored.
- Push: DI_valid=1 writes DI[127:64] into the FIFO, in any state.
  - If the FIFO is full and no pop occurs that cycle, the data is dropped and overflow<=1.
  - Push and pop in the same cycle while full: push accepted, count unchanged.
- advance = sa_ready && ((state==STREAM && fifo_not_empty) || state==FLUSH).
  - All delay lines shift only on advance; when advance=0 everything freezes.
  - This preserves diagonal alignment across bubbles and stalls.
- Skew: lane r passes through r register stages (lane 0 has none) before the output register.
- DO/lane_valid/DO_valid are registered; DO_valid(t+1)=advance(t); DO holds its value when DO_valid=0.
- STREAM advance: pops one vector into the lane-0 input; all lanes' input lane_valid=1.
- FLUSH advance: injects zeros; input lane_valid=0.
- FSM:
  - IDLE -> STREAM when fifo_not_empty; vcnt<=0.
  - STREAM: vcnt increments on each pop. On the pop where vcnt==channel_reg-1 -> FLUSH, fcnt<=0.
  - FLUSH: fcnt increments on advance. On the advance where fcnt==ROWS-2 -> DONE (ROWS-1 flush beats total).
  - DONE: done=1 for exactly one cycle -> IDLE.
  - Vectors already in the FIFO for the next tile wait until IDLE re-enters STREAM.
- Latency: first vector lane 0 appears on DO 1 cycle after its pop advance; lane r appears r advances later.
  - A tile of N vectors yields N+ROWS-1 DO_valid beats.

Optional Feature:
- Macro SKEW_STALL_CNT_EN.
- Defined: adds output stall_cnt[15:0], counting cycles in STREAM/FLUSH with sa_ready=0 or an empty FIFO in STREAM.
  - Saturates at 16'hFFFF.
  - Clears on reset and on a channel config.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- define.v adds:
  - SA_ROWS=8, SA_DATA_W=8
  - OP_CFG_CHANNEL=3'b000
  - state encodings SKW_IDLE/SKW_STREAM/SKW_FLUSH/SKW_DONE
  - WORD_SIZE and DATA_MAX_BITS reuse the existing definitions.
- Sub-module: sync_fifo (parameterised width/depth, sync active-low reset, full/empty, push/pop), reusable elsewhere.

Test Plan:
- Config channel=4, then push 4 vectors with lanes {r+1 + 16*k}, sa_ready=1. Expect 11 DO_valid beats:
  - beat 0: DO=64'h0100000000000000, lane_valid=8'b10000000
  - beat 7: lane7=8'h08
  - done pulse 1 cycle after the last beat.
- Same stream with sa_ready toggling 1,0,1,0. Expect identical DO sequence with gaps, and diagonal alignment preserved.
- Push 17 vectors back-to-back with sa_ready=0. Expect overflow=1 after the 17th push, FIFO holding the first 16, DO_valid=0 throughout.
- Tile 1 with channel=2 while 2 more vectors arrive during FLUSH. Expect done, then IDLE->STREAM next cycle, and tile 2 output uncorrupted.
- config_valid in STREAM with channel=9. Expect no effect, the tile still ends after 4 vectors; channel=0 in IDLE leaves channel_reg unchanged.
- rst=0 for 1 cycle mid-FLUSH. Expect all outputs 0 next cycle, FIFO empty, no done pulse.
